lifo_stack: RTL and testbench

Parametrised LIFO stack: full `2**W` entry depth, occupancy count, almost-full/almost-empty thresholds, replace-top on simultaneous push/pop, synchronous clear and registered overflow/underflow error pulses. It serves as the general-purpose stack for datapath and controller designs that need depth visibility and error reporting, such as expression evaluators and return-address stacks.

---
 rtl/lifo_stack.sv | 102 ++++++++++
 tb/tb_lifo_stack.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_stack.sv
// LIFO stack with occupancy count, threshold flags, replace-top on
// simultaneous push/pop, synchronous clear and registered error pulses.
module lifo_stack #(
  parameter int B  = 8,
  parameter int W  = 4,
  parameter int AF = 14,
  parameter int AE = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [B-1:0] w_data,
  output logic [B-1:0] r_data,
  output logic [W:0]   count,
  output logic         empty,
  output logic         full,
  output logic         almost_empty,
  output logic         almost_full,
  output logic         overflow,
  output logic         underflow
);

  localparam int          DEPTH   = 2**W;
  localparam logic [W:0]  DEPTH_C = (W+1)'(DEPTH);
  localparam logic [W:0]  AF_C    = (W+1)'(AF);
  localparam logic [W:0]  AE_C    = (W+1)'(AE);
  localparam logic [W:0]  ONE     = (W+1)'(1);

  logic [B-1:0] mem [DEPTH];
  logic [W:0]   sp;
  logic [W:0]   sp_nxt;
  logic [W-1:0] top_addr;
  logic [W-1:0] wr_addr;
  logic         wr_en;
  logic         ovf_nxt;
  logic         udf_nxt;

  // Wraps to DEPTH-1 when sp == DEPTH, which is the real top when full.
  assign top_addr = sp[W-1:0] - W'(1);

  assign count        = sp;
  assign empty        = (sp == '0);
  assign full         = (sp == DEPTH_C);
  assign almost_empty = (sp <= AE_C);
  assign almost_full  = (sp >= AF_C);
  assign r_data       = empty ? '0 : mem[top_addr];

  always_comb begin
    sp_nxt  = sp;
    wr_en   = 1'b0;
    wr_addr = sp[W-1:0];
    ovf_nxt = 1'b0;
    udf_nxt = 1'b0;
    if (clear) begin
      sp_nxt = '0;
    end else begin
      unique case (1'b1)
        (push && !pop): begin
          if (full) begin
            ovf_nxt = 1'b1;
          end else begin
            wr_en  = 1'b1;
            sp_nxt = sp + ONE;
          end
        end
        (!push && pop): begin
          if (empty) udf_nxt = 1'b1;
          else       sp_nxt  = sp - ONE;
        end
        (push && pop): begin
          wr_en = 1'b1;
          if (empty) begin
            sp_nxt  = ONE;
            udf_nxt = 1'b1;
          end else begin
            wr_addr = top_addr;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp        <= sp_nxt;
      overflow  <= ovf_nxt;
      underflow <= udf_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= w_data;
  end

endmodule

// File: tb/tb_lifo_stack.sv
// Bench for lifo_stack: directed scenarios plus randomized traffic
// checked against a queue-based model.
module tb_lifo_stack;

  localparam int B = 8;
  localparam int W = 4;
  localparam int DEPTH = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         clear = 1'b0;
  logic         push = 1'b0;
  logic         pop = 1'b0;
  logic [B-1:0] w_data = '0;
  logic [B-1:0] r_data;
  logic [W:0]   count;
  logic         empty, full, almost_empty, almost_full;
  logic         overflow, underflow;

  int checks = 0;
  int errors = 0;

  logic [B-1:0] q[$];
  logic         m_ovf = 1'b0;
  logic         m_udf = 1'b0;

  lifo_stack #(.B(B), .W(W), .AF(AF), .AE(AE)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .push(push), .pop(pop),
    .w_data(w_data), .r_data(r_data), .count(count), .empty(empty),
    .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic model_step(input logic c, input logic pu, input logic po,
                            input logic [B-1:0] d);
    m_ovf = 1'b0;
    m_udf = 1'b0;
    if (c) begin
      q.delete();
    end else if (pu && !po) begin
      if (q.size() == DEPTH) m_ovf = 1'b1;
      else q.push_back(d);
    end else if (!pu && po) begin
      if (q.size() == 0) m_udf = 1'b1;
      else void'(q.pop_back());
    end else if (pu && po) begin
      if (q.size() == 0) begin
        q.push_back(d);
        m_udf = 1'b1;
      end else begin
        q[q.size()-1] = d;
      end
    end
  endtask

  task automatic do_op(input logic c, input logic pu, input logic po,
                       input logic [B-1:0] d);
    clear = c; push = pu; pop = po; w_data = d;
    @(posedge clk); #1;
    model_step(c, pu, po, d);
    clear = 0; push = 0; pop = 0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #2;
    checks++;
    if (count !== 0 || empty !== 1 || full !== 0 || almost_empty !== 1 ||
        almost_full !== 0 || r_data !== 0 || overflow !== 0 || underflow !== 0) begin
      errors++;
      $display("FAIL reset: count=%0d empty=%b full=%b ae=%b af=%b r=%h ovf=%b udf=%b, need 0 1 0 1 0 00 0 0",
               count, empty, full, almost_empty, almost_full, r_data, overflow, underflow);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    q.delete(); m_ovf = 0; m_udf = 0;
  endtask

  task automatic test_basic;
    do_op(0, 1, 0, 8'h11);
    do_op(0, 1, 0, 8'h22);
    do_op(0, 1, 0, 8'h33);
    checks++;
    if (count !== 3 || r_data !== 8'h33 || empty !== 0 || almost_empty !== 0) begin
      errors++;
      $display("FAIL basic_push: count=%0d r=%h empty=%b ae=%b, need 3 33 0 0",
               count, r_data, empty, almost_empty);
    end
    do_op(0, 0, 1, 8'h00);
    checks++;
    if (count !== 2 || r_data !== 8'h22 || almost_empty !== 1) begin
      errors++;
      $display("FAIL basic_pop: count=%0d r=%h ae=%b, need 2 22 1",
               count, r_data, almost_empty);
    end
  endtask

  task automatic test_fill_overflow;
    do_op(1, 0, 0, 8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      do_op(0, 1, 0, B'(i));
      checks++;
      if (almost_full !== (i + 1 >= AF) || count !== (W+1)'(i + 1)) begin
        errors++;
        $display("FAIL fill_af: count=%0d af=%b, need %0d %b",
                 count, almost_full, i + 1, (i + 1 >= AF));
      end
    end
    checks++;
    if (full !== 1 || count !== 16 || r_data !== 8'h0F) begin
      errors++;
      $display("FAIL fill_full: full=%b count=%0d r=%h, need 1 16 0f",
               full, count, r_data);
    end
    do_op(0, 1, 0, 8'hAA);
    checks++;
    if (overflow !== 1 || r_data !== 8'h0F || count !== 16) begin
      errors++;
      $display("FAIL overflow_pulse: ovf=%b r=%h count=%0d, need 1 0f 16",
               overflow, r_data, count);
    end
    do_op(0, 0, 0, 8'h00);
    checks++;
    if (overflow !== 0) begin
      errors++;
      $display("FAIL overflow_one_cycle: ovf=%b, need 0", overflow);
    end
  endtask

  task automatic test_replace_drain;
    logic [B-1:0] exp;
    do_op(0, 1, 1, 8'h55);
    checks++;
    if (r_data !== 8'h55 || count !== 16 || overflow !== 0) begin
      errors++;
      $display("FAIL replace_full: r=%h count=%0d ovf=%b, need 55 16 0",
               r_data, count, overflow);
    end
    for (int i = 0; i < DEPTH; i++) begin
      exp = (i == 0) ? 8'h55 : B'(DEPTH - 1 - i);
      checks++;
      if (r_data !== exp) begin
        errors++;
        $display("FAIL drain_order[%0d]: r=%h, need %h", i, r_data, exp);
      end
      do_op(0, 0, 1, 8'h00);
    end
    checks++;
    if (empty !== 1 || r_data !== 0 || count !== 0) begin
      errors++;
      $display("FAIL drain_empty: empty=%b r=%h count=%0d, need 1 00 0",
               empty, r_data, count);
    end
  endtask

  task automatic test_underflow;
    do_op(0, 0, 1, 8'h00);
    checks++;
    if (underflow !== 1 || count !== 0) begin
      errors++;
      $display("FAIL underflow_pulse: udf=%b count=%0d, need 1 0", underflow, count);
    end
    do_op(0, 0, 0, 8'h00);
    checks++;
    if (underflow !== 0) begin
      errors++;
      $display("FAIL underflow_one_cycle: udf=%b, need 0", underflow);
    end
    do_op(0, 1, 1, 8'h77);
    checks++;
    if (count !== 1 || r_data !== 8'h77 || underflow !== 1) begin
      errors++;
      $display("FAIL pushpop_empty: count=%0d r=%h udf=%b, need 1 77 1",
               count, r_data, underflow);
    end
  endtask

  task automatic test_back_to_back;
    do_op(1, 0, 0, 8'h00);
    do_op(0, 0, 1, 8'h00);
    do_op(0, 0, 1, 8'h00);
    checks++;
    if (underflow !== 1) begin
      errors++;
      $display("FAIL b2b_underflow: udf=%b, need 1", underflow);
    end
    do_op(0, 1, 0, 8'h9C);
    checks++;
    if (underflow !== 0 || r_data !== 8'h9C) begin
      errors++;
      $display("FAIL b2b_recover: udf=%b r=%h, need 0 9c", underflow, r_data);
    end
  endtask

  task automatic test_clear_reset;
    do_op(1, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) do_op(0, 1, 0, B'(8'h40 + i));
    do_op(1, 1, 0, 8'hEE);
    checks++;
    if (count !== 0 || empty !== 1 || overflow !== 0 || underflow !== 0) begin
      errors++;
      $display("FAIL clear_push: count=%0d empty=%b ovf=%b udf=%b, need 0 1 0 0",
               count, empty, overflow, underflow);
    end
    for (int i = 0; i < 3; i++) do_op(0, 1, 0, B'(8'h60 + i));
    push = 1; w_data = 8'h99;
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (count !== 0 || empty !== 1 || r_data !== 0) begin
      errors++;
      $display("FAIL async_reset: count=%0d empty=%b r=%h, need 0 1 00",
               count, empty, r_data);
    end
    @(posedge clk); #1;
    push = 0;
    reset_n = 1'b1;
    q.delete(); m_ovf = 0; m_udf = 0;
  endtask

  task automatic test_random;
    int r, pu_pct, sz, bad;
    logic c, pu, po;
    logic [B-1:0] exp_r;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      pu_pct = ((i / 100) % 2 == 0) ? 70 : 30;
      r  = $urandom_range(0, 99);
      c  = (r < 2);
      pu = ($urandom_range(0, 99) < pu_pct);
      po = ($urandom_range(0, 99) < 100 - pu_pct);
      do_op(c, pu, po, B'($urandom));
      sz = q.size();
      exp_r = (sz == 0) ? '0 : q[sz-1];
      checks++;
      if (count !== (W+1)'(sz) || r_data !== exp_r || empty !== (sz == 0) ||
          full !== (sz == DEPTH) || almost_empty !== (sz <= AE) ||
          almost_full !== (sz >= AF) || overflow !== m_ovf || underflow !== m_udf) begin
        errors++;
        if (bad < 10)
          $display("FAIL random[%0d]: count=%0d r=%h e=%b f=%b ae=%b af=%b ovf=%b udf=%b, need %0d %h ovf=%b udf=%b",
                   i, count, r_data, empty, full, almost_empty, almost_full,
                   overflow, underflow, sz, exp_r, m_ovf, m_udf);
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_overflow();
    test_replace_drain();
    test_underflow();
    test_back_to_back();
    test_clear_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
